// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives a 1-cycle synchronous ROM and
// delivers {pc, instr} to decode through a 2-entry valid/ready FIFO.
module instr_fetch_unit #(
  parameter int unsigned     ROM_AW   = 6,
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clka,
  input  logic              rst_n,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [PC_W-1:0]   out_pc
);

  logic [PC_W-1:0] r_pc;
  logic            r_inflight;
  logic [PC_W-1:0] r_inflight_pc;
  logic [1:0]      r_count;
  logic [31:0]     r_head_instr;
  logic [PC_W-1:0] r_head_pc;
  logic [31:0]     r_tail_instr;
  logic [PC_W-1:0] r_tail_pc;

  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic [2:0]      w_occ;
  logic [1:0]      w_count_nx;
  logic [31:0]     w_head_instr_nx;
  logic [PC_W-1:0] w_head_pc_nx;
  logic [31:0]     w_tail_instr_nx;
  logic [PC_W-1:0] w_tail_pc_nx;
  logic            w_unused;

  assign w_unused  = ^redirect_pc[1:0];
  assign rom_addr  = r_pc[ROM_AW+1:2];
  assign out_valid = (r_count != 2'd0);
  assign out_instr = r_head_instr;
  assign out_pc    = r_head_pc;

  assign w_pop  = out_valid & out_ready;
  assign w_push = r_inflight & ~redirect_valid;

  // Each outstanding read holds a credit for one FIFO slot.
  assign w_occ   = {1'b0, r_count}
                 + {2'b00, r_inflight}
                 - {2'b00, w_pop};
  assign w_issue = ~redirect_valid & (w_occ < 3'd2);

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_pc       <= {redirect_pc[PC_W-1:2], 2'b00};
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc          <= r_pc + PC_W'(4);
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  always_comb begin
    w_count_nx      = r_count;
    w_head_instr_nx = r_head_instr;
    w_head_pc_nx    = r_head_pc;
    w_tail_instr_nx = r_tail_instr;
    w_tail_pc_nx    = r_tail_pc;
    if (redirect_valid) begin
      w_count_nx = 2'd0;
    end else begin
      unique case (1'b1)
        (w_push && !w_pop): begin
          if (r_count == 2'd0) begin
            w_head_instr_nx = rom_data;
            w_head_pc_nx    = r_inflight_pc;
          end else begin
            w_tail_instr_nx = rom_data;
            w_tail_pc_nx    = r_inflight_pc;
          end
          w_count_nx = r_count + 2'd1;
        end
        (!w_push && w_pop): begin
          w_head_instr_nx = r_tail_instr;
          w_head_pc_nx    = r_tail_pc;
          w_count_nx      = r_count - 2'd1;
        end
        (w_push && w_pop): begin
          if (r_count == 2'd2) begin
            w_head_instr_nx = r_tail_instr;
            w_head_pc_nx    = r_tail_pc;
            w_tail_instr_nx = rom_data;
            w_tail_pc_nx    = r_inflight_pc;
          end else begin
            w_head_instr_nx = rom_data;
            w_head_pc_nx    = r_inflight_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= 2'd0;
      r_head_instr <= '0;
      r_head_pc    <= '0;
      r_tail_instr <= '0;
      r_tail_pc    <= '0;
    end else begin
      r_count      <= w_count_nx;
      r_head_instr <= w_head_instr_nx;
      r_head_pc    <= w_head_pc_nx;
      r_tail_instr <= w_tail_instr_nx;
      r_tail_pc    <= w_tail_pc_nx;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: ROM model plus an in-order
// delivery model (expected next pc, instr = ROM[pc>>2]).
module tb_instr_fetch_unit;

  logic        clka = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  instr_fetch_unit #(
    .ROM_AW(6), .PC_W(32), .RESET_PC(32'h0)
  ) dut (
    .clka(clka),
    .rst_n(rst_n),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc)
  );

  always #5 clka = ~clka;

  logic [31:0] rom [64];
  always @(posedge clka) rom_data <= rom[rom_addr];

  int total = 0;
  int bad = 0;
  int ntx = 0;
  logic seen100 = 1'b0;
  logic [31:0] exp_pc = '0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, score any transfer, check hold.
  task automatic cyc(input logic rdy,
                     input logic rv,
                     input logic [31:0] rpc);
    logic s_v, s_r, s_rv;
    logic [31:0] s_pc, s_in;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    if (out_valid && rdy) begin
      chk("xfer_pc", 64'(out_pc), 64'(exp_pc));
      chk("xfer_ins", 64'(out_instr), 64'(rom[exp_pc[7:2]]));
      if (out_pc == 32'h100) seen100 = 1'b1;
      exp_pc = exp_pc + 32'd4;
      ntx++;
    end
    if (rv) exp_pc = rpc & ~32'h3;
    s_v = out_valid; s_r = rdy; s_rv = rv;
    s_pc = out_pc; s_in = out_instr;
    @(posedge clka); #1;
    redirect_valid = 1'b0;
    if (s_v && !s_r && !s_rv) begin
      chk("hold_v", 64'(out_valid), 64'd1);
      chk("hold_pc", 64'(out_pc), 64'(s_pc));
      chk("hold_ins", 64'(out_instr), 64'(s_in));
    end
  endtask

  task automatic release_and_start();
    rst_n = 1'b1;
    exp_pc = 32'h0;
    cyc(1'b1, 1'b0, 32'h0);
    chk("start_v0", 64'(out_valid), 64'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("start_v1", 64'(out_valid), 64'd1);
    chk("start_pc", 64'(out_pc), 64'd0);
  endtask

  task automatic steady(input int n);
    for (int i = 0; i < n; i++) begin
      chk("steady_v", 64'(out_valid), 64'd1);
      cyc(1'b1, 1'b0, 32'h0);
    end
  endtask

  task automatic redirect_to(input logic rdy,
                             input logic [31:0] tgt);
    cyc(rdy, 1'b1, tgt);
    chk("rd_v0a", 64'(out_valid), 64'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("rd_v0b", 64'(out_valid), 64'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("rd_v1", 64'(out_valid), 64'd1);
    chk("rd_pc", 64'(out_pc), 64'(tgt & ~32'h3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++)
      rom[i] = (i >= 4 && i < 12) ? (32'h1000_0000 | i) : 32'h0;
    rom[0] = 32'he3a00004;
    rom[1] = 32'he3a01001;
    rom[2] = 32'he3a02002;
    rom[3] = 32'he3a0300a;

    repeat (3) @(posedge clka);
    #1;
    chk("rst_v", 64'(out_valid), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_ins", 64'(out_instr), 64'd0);
    chk("rst_addr", 64'(rom_addr), 64'd0);

    // 1: back-to-back delivery from reset
    release_and_start();
    chk("t1_ins0", 64'(out_instr), 64'he3a00004);
    steady(4);

    // 2: backpressure holds, issue stops two words ahead
    for (int i = 0; i < 10; i++) begin
      chk("t2_v", 64'(out_valid), 64'd1);
      cyc(1'b0, 1'b0, 32'h0);
    end
    chk("t2_addr", 64'(rom_addr),
        64'(((exp_pc + 32'd8) >> 2) & 32'h3f));
    steady(8);

    // 3: redirect with FIFO full, then with a read in flight
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0);
    redirect_to(1'b0, 32'h0000000E);
    chk("t3_ins", 64'(out_instr), 64'he3a0300a);
    steady(3);
    redirect_to(1'b1, 32'h00000004);
    steady(3);

    // 4: random backpressure and occasional redirects
    ntx = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 31) == 0)
        cyc(1'($urandom_range(0, 1)), 1'b1,
            $urandom_range(0, 127));
      else
        cyc(1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end
    chk("t4_progress", 64'(ntx > 100), 64'd1);

    // 5: wrap of the ROM word address
    redirect_to(1'b1, 32'h000000F0);
    steady(8);
    chk("t5_seen100", 64'(seen100), 64'd1);

    // 6: asynchronous reset mid-stream
    steady(2);
    rst_n = 1'b0;
    #1;
    chk("t6_v", 64'(out_valid), 64'd0);
    chk("t6_pc", 64'(out_pc), 64'd0);
    chk("t6_ins", 64'(out_instr), 64'd0);
    chk("t6_addr", 64'(rom_addr), 64'd0);
    @(posedge clka); #1;
    release_and_start();
    steady(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
